// File: rtl/prog_loader.sv
// prog_loader
// Boot-stage loader for the processor's instruction memory. It takes a program
// as a byte stream over a valid/ready handshake, builds big-endian 16-bit
// instruction words and writes them through the instruction-memory load port.
// The processor is held via cpu_hold until the whole image has been written
// and the trailing XOR checksum matches.
//
// Stream: COUNT_HI, COUNT_LO, COUNT x (WORD_HI, WORD_LO), CHK
//         CHK = XOR of every byte before it, including the count bytes.
//
// Ports
//   clock      : single clock, rising edge
//   clear      : asynchronous active-low reset
//   byte_in    : stream data
//   byte_valid : byte_in is valid
//   byte_ready : loader accepts a byte this cycle
//   restart    : synchronous reload request, honoured only in DONE or ERR
//   ins_load   : instruction word being written
//   l_addr     : byte address of the write (always even)
//   load       : one-cycle write strobe to instruction memory
//   cpu_hold   : processor must stay held while 1
//   done       : image loaded and checksum verified
//   error      : load aborted (over-range count or checksum mismatch)
module prog_loader #(
  parameter int MEM_BYTES  = 64,
  parameter int START_ADDR = 0
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  input  logic        restart,
  output logic [15:0] ins_load,
  output logic [15:0] l_addr,
  output logic        load,
  output logic        cpu_hold,
  output logic        done,
  output logic        error
);

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_CNT_HI  = 4'd1,
    ST_CNT_LO  = 4'd2,
    ST_WORD_HI = 4'd3,
    ST_WORD_LO = 4'd4,
    ST_WRITE   = 4'd5,
    ST_CHECK   = 4'd6,
    ST_DONE    = 4'd7,
    ST_ERR     = 4'd8
  } state_t;

  // Largest word count that fits between START_ADDR and the end of memory.
  localparam logic [16:0] MAX_WORDS = 17'((MEM_BYTES - START_ADDR) / 2);
  localparam logic [15:0] START_A   = 16'(START_ADDR);

  // Running checksum accumulation.
  function automatic logic [7:0] chk_accum(input logic [7:0] acc, input logic [7:0] b);
    chk_accum = acc ^ b;
  endfunction

  // States in which the loader accepts a stream byte.
  function automatic logic is_rx_state(input state_t st);
    case (st)
      ST_CNT_HI, ST_CNT_LO, ST_WORD_HI, ST_WORD_LO, ST_CHECK: is_rx_state = 1'b1;
      default:                                               is_rx_state = 1'b0;
    endcase
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [7:0]  cnt_hi_r;
  logic [15:0] remaining_r;
  logic [7:0]  xor_r;
  logic [15:0] ins_load_r;
  logic [15:0] l_addr_r;
  logic        byte_ready_r;
  logic        load_r;
  logic        cpu_hold_r;
  logic        done_r;
  logic        error_r;
  logic        xfer_s;
  logic [15:0] count_s;

  // byte_ready_r always mirrors the current state, so it doubles as the accept decode.
  assign xfer_s  = byte_valid & byte_ready_r;
  assign count_s = {cnt_hi_r, byte_in};

  // Next-state decode.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_CNT_HI;
      end
      ST_CNT_HI: begin
        if (xfer_s) state_nxt_s = ST_CNT_LO;
        else        state_nxt_s = state_r;
      end
      ST_CNT_LO: begin
        // Range check happens before any write, so an over-range count never loads.
        if (!xfer_s)                          state_nxt_s = state_r;
        else if ({1'b0, count_s} > MAX_WORDS) state_nxt_s = ST_ERR;
        else if (count_s == 16'd0)            state_nxt_s = ST_CHECK;
        else                                  state_nxt_s = ST_WORD_HI;
      end
      ST_WORD_HI: begin
        if (xfer_s) state_nxt_s = ST_WORD_LO;
        else        state_nxt_s = state_r;
      end
      ST_WORD_LO: begin
        if (xfer_s) state_nxt_s = ST_WRITE;
        else        state_nxt_s = state_r;
      end
      ST_WRITE: begin
        if (remaining_r == 16'd1) state_nxt_s = ST_CHECK;
        else                      state_nxt_s = ST_WORD_HI;
      end
      ST_CHECK: begin
        if (!xfer_s)                state_nxt_s = state_r;
        else if (byte_in == xor_r)  state_nxt_s = ST_DONE;
        else                        state_nxt_s = ST_ERR;
      end
      ST_DONE, ST_ERR: begin
        if (restart) state_nxt_s = ST_IDLE;
        else         state_nxt_s = state_r;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and Moore outputs, registered from the next state so they
  // change in the same cycle the state does.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state_r      <= ST_IDLE;
      byte_ready_r <= 1'b0;
      load_r       <= 1'b0;
      cpu_hold_r   <= 1'b1;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      state_r      <= state_nxt_s;
      byte_ready_r <= is_rx_state(state_nxt_s);
      load_r       <= (state_nxt_s == ST_WRITE);
      cpu_hold_r   <= (state_nxt_s != ST_DONE);
      done_r       <= (state_nxt_s == ST_DONE);
      error_r      <= (state_nxt_s == ST_ERR);
    end
  end

  // Datapath: count, word assembly, write address and running checksum.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_hi_r    <= 8'h00;
      remaining_r <= 16'h0000;
      xor_r       <= 8'h00;
      ins_load_r  <= 16'h0000;
      l_addr_r    <= START_A;
    end else begin
      case (state_r)
        ST_CNT_HI: begin
          if (xfer_s) begin
            cnt_hi_r <= byte_in;
            xor_r    <= chk_accum(xor_r, byte_in);
          end
        end
        ST_CNT_LO: begin
          if (xfer_s) begin
            remaining_r <= count_s;
            xor_r       <= chk_accum(xor_r, byte_in);
          end
        end
        ST_WORD_HI: begin
          if (xfer_s) begin
            ins_load_r[15:8] <= byte_in;
            xor_r            <= chk_accum(xor_r, byte_in);
          end
        end
        ST_WORD_LO: begin
          if (xfer_s) begin
            ins_load_r[7:0] <= byte_in;
            xor_r           <= chk_accum(xor_r, byte_in);
          end
        end
        ST_WRITE: begin
          remaining_r <= remaining_r - 16'd1;
          // The address stays on the last word so it never points past the image.
          if (remaining_r != 16'd1) l_addr_r <= l_addr_r + 16'd2;
        end
        ST_DONE, ST_ERR: begin
          if (restart) begin
            l_addr_r <= START_A;
            xor_r    <= 8'h00;
          end
        end
        default: begin
          cnt_hi_r <= cnt_hi_r;
        end
      endcase
    end
  end

  assign byte_ready = byte_ready_r;
  assign ins_load   = ins_load_r;
  assign l_addr     = l_addr_r;
  assign load       = load_r;
  assign cpu_hold   = cpu_hold_r;
  assign done       = done_r;
  assign error      = error_r;

endmodule

// File: tb/tb_prog_loader.sv
// Directed testbench for prog_loader: drives byte streams, models the
// instruction memory from the load port and checks outputs against
// hand-computed values.
module tb_prog_loader;

  logic        clock;
  logic        clear;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        restart;
  logic [15:0] ins_load;
  logic [15:0] l_addr;
  logic        load;
  logic        cpu_hold;
  logic        done;
  logic        error;

  int n_checks = 0;
  int n_pass   = 0;
  int edge_cnt = 0;
  int n_loads  = 0;
  logic [7:0]  mem [0:63];
  logic [15:0] log_data [0:63];
  logic [15:0] log_addr [0:63];
  logic [7:0]  tx_q [$];

  prog_loader #(.MEM_BYTES(64), .START_ADDR(0)) dut (
    .clock      (clock),
    .clear      (clear),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .restart    (restart),
    .ins_load   (ins_load),
    .l_addr     (l_addr),
    .load       (load),
    .cpu_hold   (cpu_hold),
    .done       (done),
    .error      (error)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edge counter for latency measurement.
  always @(posedge clock) edge_cnt <= edge_cnt + 1;

  // Instruction memory model: load is high for a whole cycle, so capture mid-cycle.
  always @(negedge clock) begin
    if (load === 1'b1) begin
      mem[l_addr[5:0]]        = ins_load[15:8];
      mem[l_addr[5:0] + 6'd1] = ins_load[7:0];
      log_data[n_loads[5:0]]  = ins_load;
      log_addr[n_loads[5:0]]  = l_addr;
      n_loads = n_loads + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Present one byte (called at a negedge); returns at the negedge after the transfer.
  task automatic send_byte(input logic [7:0] b);
    int  budget;
    bit  ok;
    ok = 1'b0;
    budget = 0;
    byte_in = b;
    byte_valid = 1'b1;
    while (!ok && budget < 50) begin
      if (byte_ready === 1'b1) ok = 1'b1;
      @(negedge clock);
      budget++;
    end
    byte_valid = 1'b0;
    if (!ok) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_q();
    while (tx_q.size() > 0) send_byte(tx_q.pop_front());
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int e0;
    int base;
    clear = 1'b0;
    byte_in = 8'h00;
    byte_valid = 1'b0;
    restart = 1'b0;
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_load",  {31'd0, load},       32'd0);
    check("rst_ins",   {16'd0, ins_load},   32'h0000);
    check("rst_addr",  {16'd0, l_addr},     32'h0000);
    check("rst_hold",  {31'd0, cpu_hold},   32'd1);
    check("rst_done",  {31'd0, done},       32'd0);
    check("rst_err",   {31'd0, error},      32'd0);

    // 1. Nominal two-word load
    clear = 1'b1;
    e0 = edge_cnt;
    check("idle_ready", {31'd0, byte_ready}, 32'd0);
    base = n_loads;
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h13, 8'h30, 8'h13, 8'h12};
    send_q();
    check("t1_latency", edge_cnt - e0, 32'd10);
    check("t1_nloads",  n_loads - base, 32'd2);
    check("t1_w0", {log_addr[base], log_data[base]},         32'h0000_2013);
    check("t1_w1", {log_addr[base+1], log_data[base+1]},     32'h0002_3013);
    check("t1_done",  {31'd0, done},     32'd1);
    check("t1_hold",  {31'd0, cpu_hold}, 32'd0);
    check("t1_err",   {31'd0, error},    32'd0);
    check("t1_ready", {31'd0, byte_ready}, 32'd0);
    check("t1_addr_final", {16'd0, l_addr}, 32'h0002);
    check("t1_mem", {mem[0], mem[1], mem[2], mem[3]}, 32'h2013_3013);

    // 6. Restart from DONE, restart ignored in WORD_HI, second image
    do_restart();
    check("t6_hold", {31'd0, cpu_hold}, 32'd1);
    check("t6_done", {31'd0, done},     32'd0);
    check("t6_addr", {16'd0, l_addr},   32'h0000);
    check("t6_idle_ready", {31'd0, byte_ready}, 32'd0);
    base = n_loads;
    send_byte(8'h00);
    send_byte(8'h01);
    restart = 1'b1;
    @(negedge clock);
    restart = 1'b0;
    check("t6_ign_ready", {31'd0, byte_ready}, 32'd1);
    check("t6_ign_hold",  {31'd0, cpu_hold},   32'd1);
    tx_q = '{8'hAB, 8'hCD, 8'h67};
    send_q();
    check("t6_nloads", n_loads - base, 32'd1);
    check("t6_w0", {log_addr[base], log_data[base]}, 32'h0000_ABCD);
    check("t6_done2", {31'd0, done}, 32'd1);
    check("t6_mem", {16'd0, mem[0], mem[1]}, 32'h0000_ABCD);

    // 2. Checksum error
    do_restart();
    base = n_loads;
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h13, 8'h30, 8'h13, 8'h13};
    send_q();
    check("t2_nloads", n_loads - base, 32'd2);
    check("t2_w1", {log_addr[base+1], log_data[base+1]}, 32'h0002_3013);
    check("t2_err",  {31'd0, error},    32'd1);
    check("t2_hold", {31'd0, cpu_hold}, 32'd1);
    check("t2_done", {31'd0, done},     32'd0);

    // 3. Over-range count
    do_restart();
    check("t3_err_clr", {31'd0, error}, 32'd0);
    base = n_loads;
    send_byte(8'h00);
    send_byte(8'h21);
    check("t3_err",   {31'd0, error},      32'd1);
    check("t3_ready", {31'd0, byte_ready}, 32'd0);
    byte_in = 8'h55;
    byte_valid = 1'b1;
    repeat (3) @(negedge clock);
    check("t3_noaccept", {31'd0, byte_ready}, 32'd0);
    byte_valid = 1'b0;
    check("t3_nloads", n_loads - base, 32'd0);
    check("t3_addr", {16'd0, l_addr}, 32'h0000);

    // 4. Zero count with valid pattern 1,0,0,1
    do_restart();
    base = n_loads;
    send_byte(8'h00);
    @(negedge clock);
    check("t4_gap_ready", {31'd0, byte_ready}, 32'd1);
    @(negedge clock);
    check("t4_gap_done", {31'd0, done}, 32'd0);
    send_byte(8'h00);
    @(negedge clock);
    @(negedge clock);
    check("t4_chk_ready", {31'd0, byte_ready}, 32'd1);
    send_byte(8'h00);
    check("t4_done",   {31'd0, done},   32'd1);
    check("t4_nloads", n_loads - base, 32'd0);

    // 5. Reset mid-load
    do_restart();
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h13};
    send_q();
    check("t5_load",  {31'd0, load},   32'd1);
    check("t5_ins",   {16'd0, ins_load}, 32'h2013);
    @(negedge clock);
    check("t5_addr2", {16'd0, l_addr}, 32'h0002);
    #2 clear = 1'b0;
    #1;
    check("t5_rst_addr",  {16'd0, l_addr},   32'h0000);
    check("t5_rst_ins",   {16'd0, ins_load}, 32'h0000);
    check("t5_rst_load",  {31'd0, load},     32'd0);
    check("t5_rst_ready", {31'd0, byte_ready}, 32'd0);
    check("t5_rst_hold",  {31'd0, cpu_hold}, 32'd1);
    base = n_loads;
    repeat (2) @(negedge clock);
    check("t5_noload_rst", n_loads - base, 32'd0);
    clear = 1'b1;
    tx_q = '{8'h00, 8'h02, 8'h20, 8'h13, 8'h30, 8'h13, 8'h12};
    send_q();
    check("t5_nloads", n_loads - base, 32'd2);
    check("t5_w0", {log_addr[base], log_data[base]}, 32'h0000_2013);
    check("t5_done", {31'd0, done}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Upstream boot stage for the processor's instruction memory. It receives a program as a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words, and drives the instruction-memory load port (`ins_load`, `l_addr`, `load`). It holds the processor through `cpu_hold` until the whole image has been written and its checksum has verified. This replaces the testbench-driven `insload`/`laddr`/`load` sequence in the top level.

## Interface

**Parameters**
- `MEM_BYTES`, 64: instruction memory size in bytes.
- `START_ADDR`, 0: byte address of the first instruction word. Must be even.

**Ports**
- `clock`, input, 1: single clock; all state changes on its rising edge.
- `clear`, input, 1: asynchronous, active-low reset.
- `byte_in`, input, 8: stream data.
- `byte_valid`, input, 1: `byte_in` is valid.
- `byte_ready`, output, 1: loader accepts a byte this cycle.
- `restart`, input, 1: synchronous reload request; honoured only in DONE or ERR.
- `ins_load`, output, 16: instruction word to write.
- `l_addr`, output, 16: byte address of the write (even).
- `load`, output, 1: one-cycle write strobe to instruction memory.
- `cpu_hold`, output, 1: processor must stay stalled or held while this is 1.
- `done`, output, 1: image loaded and checksum verified.
- `error`, output, 1: load aborted.

## Operation

**Stream format:** COUNT_HI, COUNT_LO, then COUNT words each sent as HI byte then LO byte, then one CHK byte. CHK is the XOR of every preceding byte, including the count bytes.

**Transfer rule:** a byte is transferred on a rising edge where `byte_valid` and `byte_ready` are both 1.

**FSM** (Moore; `byte_ready` is decoded from state):
- **IDLE**: `byte_ready`=0. Always goes to CNT_HI on the next edge.
- **CNT_HI**: `byte_ready`=1. On transfer, latch the count high byte and go to CNT_LO.
- **CNT_LO**: `byte_ready`=1. On transfer, latch the count low byte. Then:
  - if count > (MEM_BYTES−START_ADDR)/2, go to ERR;
  - else if count = 0, go to CHECK;
  - else go to WORD_HI.
- **WORD_HI**: `byte_ready`=1. On transfer, latch `ins_load[15:8]` and go to WORD_LO.
- **WORD_LO**: `byte_ready`=1. On transfer, latch `ins_load[7:0]` and go to WRITE.
- **WRITE**: `byte_ready`=0, `load`=1 for exactly this cycle, with `ins_load` and `l_addr` stable. On the next edge:
  - `l_addr` += 2 and the remaining-word count decrements;
  - go to CHECK if the remaining count reaches 0, else to WORD_HI.
- **CHECK**: `byte_ready`=1. On transfer, compare the received byte against the running XOR. Go to DONE on a match, else to ERR.
- **DONE**: `done`=1, `cpu_hold`=0, `byte_ready`=0.
- **ERR**: `error`=1, `cpu_hold`=1, `byte_ready`=0.

**Restart:** `restart`=1 in DONE or ERR returns to IDLE and:
- restores `l_addr` to START_ADDR;
- clears the running XOR, `done` and `error`;
- sets `cpu_hold`=1.

`restart` is ignored in all other states.

**Running XOR:** updated on every transfer except the CHK byte.

**Arithmetic:**
- The count is 16 bits unsigned and is range-checked before any write. This covers a count of 0xFFFF.
- `l_addr` never exceeds START_ADDR + 2·(count−1).
- `load` never asserts in ERR or after an over-range count.

**Input handling:**
- `byte_valid` may drop for any number of cycles in any receiving state; the state holds.
- `byte_in` is ignored when `byte_ready`=0.

## Timing

**Reset values** (while `clear`=0):
- state IDLE
- `byte_ready` 0, `load` 0
- `ins_load` 0x0000
- `l_addr` START_ADDR
- `cpu_hold` 1, `done` 0, `error` 0
- running XOR 0

**Reset mid-load:** asserting `clear` at any point aborts the load immediately. Words already written stay in memory. No `load` pulse may occur after `clear` falls.

**Latency:**
- First `byte_ready`=1 occurs in the 2nd cycle after `clear` rises.
- With `byte_valid` held high, each word takes 3 cycles: HI, LO, WRITE.
- An N-word image reaches DONE after 2 + 3N + 1 transfer cycles following IDLE.
- `done`, `cpu_hold` and `error` change in the cycle the state enters DONE or ERR.

**Memory-side timing:** `load` is high for exactly one clock per word. `ins_load` and `l_addr` are registered and constant across that whole cycle, so instruction memory captures the word on the rising edge at the end of WRITE.

## Test plan

1. **Nominal two-word load.** Stream 00 02 20 13 30 13 12, `byte_valid` held high. Required:
   - `load` pulses with (0x2013 @ 0x0000) then (0x3013 @ 0x0002);
   - DONE is reached with `done`=1 and `cpu_hold`=0;
   - instruction memory bytes 0..3 read 20 13 30 13.
2. **Checksum error.** Same stream with CHK=0x13. Required: both writes occur, then ERR with `error`=1, `cpu_hold`=1 and `done`=0.
3. **Over-range count.** Count 00 21 (33 > 32). Required: ERR immediately after COUNT_LO, no `load` pulse, and the following bytes are not accepted (`byte_ready`=0).
4. **Zero count with throttling.** Stream 00 00 00, with `byte_valid` toggling 1,0,0,1,… Required: DONE with no `load` pulse. During gaps, state and outputs hold.
5. **Reset mid-load.** Pulse `clear` low after the first WRITE. Required:
   - all outputs return to their reset values asynchronously;
   - after release, a full reload of stream 1 writes at `l_addr` 0x0000 again.
6. **Restart.** From DONE, assert `restart` for one cycle. Required: IDLE, then `cpu_hold`=1, `done`=0 and `l_addr`=START_ADDR. A second image loads correctly. `restart` asserted during WORD_HI has no effect.
